// File: rtl/mult_pipe_param_pkg.sv
// Shared definitions for the parametrised pipelined multiplier: sizing
// helpers and the control word that travels beside the data in every stage.
package mult_pipe_pkg;

  // Widest tag any instance may carry; users slice the low TAG_W bits.
  localparam int TAG_MAX = 16;

  typedef struct packed {
    logic               valid;
    logic               neg;
    logic [TAG_MAX-1:0] tag;
  } stage_ctl_t;

  // Ceiling log2 for elaboration-time sizing (valid for 1..2^31).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Register stages from acceptance to output: input reg, tree, output reg.
  function automatic int calc_lat(input int width);
    return clog2(width) + 2;
  endfunction

endpackage

// File: rtl/mult_pipe_param_if.sv
// Operand/result bundle of the multiplier.
// Handshake: a word moves on a rising edge where valid && ready are both 1.
// A producer holds its word stable while valid=1 and ready=0; ready may
// depend combinationally on the far side (in_ready follows out_ready).
interface mult_pipe_param_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_prod, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_prod, out_tag
  );
endinterface

// File: rtl/mult_pipe_param_add_lvl.sv
// One registered level of the partial-product adder tree: sums adjacent
// pairs of N_IN operands of W bits and forwards the control word.
module mult_pipe_add_lvl
  import mult_pipe_pkg::*;
#(
  parameter int N_IN = 8,
  parameter int W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [N_IN*W-1:0]     din,
  input  stage_ctl_t            ctl_in,
  output logic [(N_IN/2)*W-1:0] dout,
  output stage_ctl_t            ctl_out
);
  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*W-1:0] sum;

  // Pairwise sums; magnitudes are bounded so W bits never overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_OUT; i++) begin
      sum[i*W +: W] = din[2*i*W +: W] + din[(2*i+1)*W +: W];
    end
  end

  // Level register; holds (bubbles included) whenever the pipe is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout    <= '0;
      ctl_out <= '0;
    end else if (en) begin
      dout    <= sum;
      ctl_out <= ctl_in;
    end
  end
endmodule

// File: rtl/mult_pipe_param.sv
// Fully pipelined WIDTH x WIDTH multiplier, signed or unsigned per operation.
// Magnitudes are multiplied through a registered binary adder tree and the
// sign is reapplied at the output register. A stalled output freezes the
// whole pipe; in_ready is the only combinational path (from out_ready).
module mult_pipe_param
  import mult_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  mult_pipe_param_if.slave bus
);
  localparam int LVL = clog2(WIDTH);
  localparam int DW  = 2 * WIDTH;

  logic             stall;
  logic             en;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  stage_ctl_t       s0_ctl;
  logic [WIDTH*DW-1:0] pp_flat;
  logic [DW-1:0]    final_sum;
  stage_ctl_t       final_ctl;

  assign stall        = bus.out_valid && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = en;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    abs_a = (bus.in_signed && bus.in_a[WIDTH-1]) ? (~bus.in_a + 1'b1) : bus.in_a;
    abs_b = (bus.in_signed && bus.in_b[WIDTH-1]) ? (~bus.in_b + 1'b1) : bus.in_b;
  end

  // Input register: captures on a transfer, loads a bubble otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_a   <= '0;
      s0_b   <= '0;
      s0_ctl <= '0;
    end else if (en) begin
      if (bus.in_valid) begin
        s0_a       <= abs_a;
        s0_b       <= abs_b;
        s0_ctl.valid <= 1'b1;
        s0_ctl.neg <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
        s0_ctl.tag <= TAG_MAX'(bus.in_tag);
      end else begin
        s0_ctl.valid <= 1'b0;
      end
    end
  end

  // Partial products of the magnitudes, one per multiplier bit.
  always_comb begin
    pp_flat = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s0_b[i]) pp_flat[i*DW +: DW] = DW'(s0_a) << i;
    end
  end

  genvar l;
  generate
    for (l = 0; l < LVL; l++) begin : g_lvl
      localparam int N_IN = WIDTH >> l;
      logic [N_IN*DW-1:0]     din;
      logic [(N_IN/2)*DW-1:0] dout;
      stage_ctl_t             cin;
      stage_ctl_t             cout;
      if (l == 0) begin : g_first
        assign din = pp_flat;
        assign cin = s0_ctl;
      end else begin : g_next
        assign din = g_lvl[l-1].dout;
        assign cin = g_lvl[l-1].cout;
      end
      mult_pipe_add_lvl #(.N_IN(N_IN), .W(DW)) u_lvl (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .din     (din),
        .ctl_in  (cin),
        .dout    (dout),
        .ctl_out (cout)
      );
    end
  endgenerate

  assign final_sum = g_lvl[LVL-1].dout;
  assign final_ctl = g_lvl[LVL-1].cout;

  // Output register: reapplies the sign, and stores zeros for a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_prod  <= '0;
      bus.out_tag   <= '0;
    end else if (en) begin
      bus.out_valid <= final_ctl.valid;
      bus.out_prod  <= final_ctl.valid ?
                       (final_ctl.neg ? (~final_sum + 1'b1) : final_sum) : '0;
      bus.out_tag   <= final_ctl.valid ? final_ctl.tag[TAG_W-1:0] : '0;
    end
  end
endmodule

// File: tb/tb_mult_pipe_param.sv
// Bench for mult_pipe_param: an 8-bit instance under directed, streaming,
// stall, reset and random-backpressure traffic, scored against an
// arithmetic model, plus a 32-bit instance with directed and random ops.
module tb_mult_pipe_param;
  import mult_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [19:0] exp_q[$];

  mult_pipe_param_if #(.WIDTH(8),  .TAG_W(4)) bus8 ();
  mult_pipe_param_if #(.WIDTH(32), .TAG_W(8)) bus32 ();

  mult_pipe_param #(.WIDTH(8),  .TAG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mult_pipe_param #(.WIDTH(32), .TAG_W(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: interpret operands as integers and multiply, modulo 2^(2w).
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic s);
    longint unsigned mask;
    longint ea;
    longint eb;
    longint p;
    logic [63:0] r;
    mask = (64'd1 << w) - 64'd1;
    ea = longint'(longint'(a) & mask);
    eb = longint'(longint'(b) & mask);
    if (s && a[w-1]) ea = ea - (longint'(1) << w);
    if (s && b[w-1]) eb = eb - (longint'(1) << w);
    p = ea * eb;
    r = 64'(p);
    if (w < 32) r = r & ((64'd1 << (2*w)) - 64'd1);
    return r;
  endfunction

  // Scoreboard for the 8-bit instance.
  always @(negedge clk) begin : mon8
    logic [19:0] e;
    logic [63:0] m;
    if (rst_n) begin
      check("in_ready_rule", 64'(bus8.in_ready), 64'(!(bus8.out_valid && !bus8.out_ready)));
      if (bus8.out_valid && bus8.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'(bus8.out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("prod8", 64'(bus8.out_prod), 64'(e[15:0]));
          check("tag8",  64'(bus8.out_tag),  64'(e[19:16]));
        end
      end
      if (!bus8.out_valid) begin
        check("idle_prod_zero", 64'(bus8.out_prod), 64'd0);
        check("idle_tag_zero",  64'(bus8.out_tag),  64'd0);
      end
      if (bus8.in_valid && bus8.in_ready) begin
        m = ref_mul(8, 32'(bus8.in_a), 32'(bus8.in_b), bus8.in_signed);
        exp_q.push_back({bus8.in_tag, m[15:0]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [3:0] tag);
    bus8.in_valid  = v;
    bus8.in_a      = a;
    bus8.in_b      = b;
    bus8.in_signed = s;
    bus8.in_tag    = tag;
  endtask

  task automatic drive8_rand(input logic v);
    drive8(v, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  // Single op on the 8-bit instance with latency and one-cycle-valid checks.
  task automatic single8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic [3:0] tag, input logic [15:0] exp);
    int n;
    drive8(1'b1, a, b, s, tag);
    step();
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      step();
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'd4);
    check({name, "_prod"}, 64'(bus8.out_prod), 64'(exp));
    check({name, "_tag"},  64'(bus8.out_tag),  64'(tag));
    step();
    check({name, "_one_cycle"}, 64'(bus8.out_valid), 64'd0);
  endtask

  // Single op on the 32-bit instance.
  task automatic single32(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [7:0] tag, input logic [63:0] exp,
                          input bit check_lat);
    int n;
    bus32.in_valid  = 1'b1;
    bus32.in_a      = a;
    bus32.in_b      = b;
    bus32.in_signed = s;
    bus32.in_tag    = tag;
    step();
    bus32.in_valid = 1'b0;
    n = 0;
    while (!bus32.out_valid && n < 30) begin
      step();
      n++;
    end
    if (check_lat) check({name, "_latency"}, 64'(n), 64'd6);
    check({name, "_prod"}, bus32.out_prod, exp);
    check({name, "_tag"},  64'(bus32.out_tag), 64'(tag));
  endtask

  initial begin : main
    int cnt;
    int first;
    int last;
    int n;
    logic [15:0] held_p;
    logic [3:0]  held_t;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    drive8(1'b0, 8'd0, 8'd0, 1'b0, 4'd0);
    bus8.out_ready  = 1'b1;
    bus32.in_valid  = 1'b0;
    bus32.in_a      = '0;
    bus32.in_b      = '0;
    bus32.in_signed = 1'b0;
    bus32.in_tag    = '0;
    bus32.out_ready = 1'b1;

    // reset state
    #22;
    check("rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("rst_out_prod",  64'(bus8.out_prod),  64'd0);
    check("rst_out_tag",   64'(bus8.out_tag),   64'd0);
    check("rst_in_ready",  64'(bus8.in_ready),  64'd1);
    check("rst32_out_valid", 64'(bus32.out_valid), 64'd0);
    check("rst32_in_ready",  64'(bus32.in_ready),  64'd1);
    rst_n = 1'b1;
    step();

    // directed products
    single8("u255x255", 8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01);
    single8("sm128xm128", 8'h80, 8'h80, 1'b1, 4'd5, 16'h4000);
    single8("sm128x127", 8'h80, 8'h7F, 1'b1, 4'd6, 16'hC080);
    single8("sm1x1", 8'hFF, 8'h01, 1'b1, 4'd7, 16'hFFFF);
    single8("s0xm5", 8'h00, 8'hFB, 1'b1, 4'd8, 16'h0000);
    single8("u128x128", 8'h80, 8'h80, 1'b0, 4'd9, 16'h4000);

    // back-to-back stream of 20 operations
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 30; i++) begin
      drive8_rand(i < 20);
      step();
      if (bus8.out_valid) begin
        if (first < 0) first = i;
        last = i;
        cnt++;
      end
    end
    check("stream_count", 64'(cnt), 64'd20);
    check("stream_contiguous", 64'(last - first), 64'd19);
    check("stream_first_latency", 64'(first), 64'd4);

    // stall with a full pipe
    for (int i = 0; i < 8; i++) begin
      drive8_rand(1'b1);
      step();
    end
    drive8_rand(1'b1);
    bus8.out_ready = 1'b0;
    #1;
    held_p = bus8.out_prod;
    held_t = bus8.out_tag;
    check("stall_valid", 64'(bus8.out_valid), 64'd1);
    check("stall_in_ready", 64'(bus8.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_in_ready_hold", 64'(bus8.in_ready), 64'd0);
      check("stall_prod_hold", 64'(bus8.out_prod), 64'(held_p));
      check("stall_tag_hold",  64'(bus8.out_tag),  64'(held_t));
    end
    bus8.out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      drive8_rand(1'b1);
      step();
    end
    bus8.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall_drained", 64'(exp_q.size()), 64'd0);

    // reset with operations in flight
    for (int i = 0; i < 3; i++) begin
      drive8_rand(1'b1);
      step();
    end
    bus8.in_valid = 1'b0;
    n = 0;
    while (!bus8.out_valid && n < 20) begin
      step();
      n++;
    end
    check("pre_reset_valid", 64'(bus8.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus8.out_valid), 64'd0);
    check("mid_rst_out_prod",  64'(bus8.out_prod),  64'd0);
    check("mid_rst_out_tag",   64'(bus8.out_tag),   64'd0);
    check("mid_rst_in_ready",  64'(bus8.in_ready),  64'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus8.out_valid) cnt++;
    end
    check("no_stale_after_reset", 64'(cnt), 64'd0);

    // random traffic with random backpressure
    drive8_rand(1'b0);
    for (int i = 0; i < 300; i++) begin
      logic took;
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus8.in_valid && bus8.in_ready;
      step();
      if (took || !bus8.in_valid) drive8_rand($urandom_range(0, 3) != 0);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    check("random_drained", 64'(exp_q.size()), 64'd0);

    // 32-bit instance
    single32("w32_uffxff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 8'hA5,
             64'hFFFFFFFE00000001, 1'b1);
    single32("w32_sm1xm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 8'h5A,
             64'h0000000000000001, 1'b1);
    single32("w32_smin_sq", 32'h80000000, 32'h80000000, 1'b1, 8'h11,
             64'h4000000000000000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      single32("w32_rand", ra, rb, rs, 8'(i), ref_mul(32, ra, rb, rs), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_pipe_param.md
# mult_pipe_param

Parametrised, fully pipelined integer multiplier with a valid/ready handshake. It is the generalised successor of the team's fixed 8-bit shift-add pipeline multiplier. It adds configurable operand width, a per-operation signed/unsigned mode, a sideband tag and output backpressure. The block sits in the datapath between an operand producer (FIFO or sequencer) and a consumer that may stall. It accepts one operation per cycle when not stalled.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, 4..32.
- TAG_W, 4, width of the sideband tag carried alongside each operation; 1..16.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operation is presented.
- in_ready  out  1  the block can accept; transfer when in_valid && in_ready.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned.
- in_tag  in  TAG_W  opaque ID, returned unchanged with the result.
- out_valid  out  1  the result is valid.
- out_ready  in  1  the consumer accepts; transfer when out_valid && out_ready.
- out_prod  out  2*WIDTH  full-precision product.
- out_tag  out  TAG_W  tag of the operation in out_prod.

## Operation
- LVL = log2(WIDTH). LAT = LVL + 2 pipeline register stages.
- Stage S0 (input register), capturing on a transfer:
  - abs_a and abs_b: magnitudes, WIDTH bits unsigned. The most negative value, e.g. -128 for WIDTH=8, maps to 2^(WIDTH-1). This fits without overflow.
  - neg = in_signed & (a_msb ^ b_msb).
  - The tag and a valid bit are also captured.
- Partial products: pp[i] = abs_b[i] ? (abs_a << i) : 0, each 2*WIDTH bits. These are combinational from S0.
- Stages S1..S_LVL form a binary adder tree, one level per stage. Each stage halves the operand count, so WIDTH → WIDTH/2 → … → 1. All sums are 2*WIDTH bits and cannot overflow.
- Stage S_LVL+1 (output register):
  - out_prod = neg ? (~sum + 1) : sum, taken modulo 2^(2*WIDTH).
  - An unsigned magnitude product of 0 with neg=1 yields 0.
- Valid and tag travel in lockstep with the data through every stage.
- out_prod and out_tag read as 0 whenever out_valid = 0. These are registered zeros, not gated combinationally.
- Stall:
  - stall = out_valid && !out_ready.
  - While stall is asserted, every pipeline register holds its value, including empty (bubble) stages.
  - in_ready = !stall. This is the only combinational path, from out_ready to in_ready.
- When a stage has no transfer, its valid bit is loaded with 0. Bubbles propagate and are never compressed.

## Timing
- Reset, asynchronous on rst_n low: all valid bits, data and tags go to 0. This gives out_valid=0, out_prod=0, out_tag=0, and in_ready=1.
- Latency: an operation accepted at rising edge k appears with out_valid=1 after edge k+LAT-1. Example: for WIDTH=8, LAT=5, so the result is visible in the cycle following edge k+4.
- Throughput: 1 operation per cycle while out_ready is held at 1.
- Simultaneous events:
  - When out_valid && out_ready and an input transfer occur in the same cycle, the pipeline advances normally.
  - A stall cycle also blocks an input transfer in the same cycle, because in_ready=0.
- Reset mid-operation: all in-flight results are discarded. No result is produced for operations accepted before reset.
- Inputs are sampled only on a transfer. in_a, in_b, in_signed and in_tag are don't-care otherwise.

## Structure
- Package mult_pipe_pkg holds:
  - the function clog2;
  - the LAT computation;
  - a packed struct stage_ctl_t {valid, neg, tag}, parametrised through TAG_W (max-width typedef sliced by users).
- Sub-module mult_pipe_add_lvl: one registered tree level.
  - Parameters N_IN and W.
  - Sums adjacent pairs, takes an enable (= !stall), and forwards stage_ctl_t.
  - It is instantiated LVL times in a generate loop.

## Test plan
- Reset, then WIDTH=8 unsigned with in_a=255, in_b=255, tag=3: out_prod=16'hFE01 and out_tag=3, presented exactly 5 cycles after acceptance, with out_valid=1 for one cycle.
- Signed mode: (-128)×(-128) → 16'h4000. (-128)×127 → 16'hC080. (-1)×1 → 16'hFFFF. 0×(-5) → 16'h0000.
- Back-to-back stream of 20 random operations, mixed signed/unsigned, with out_ready=1: results arrive in order, one per cycle, matching a reference model with matching tags.
- out_ready low for 3 cycles while the pipeline is full: in_ready=0 during the stall, out_prod and out_tag remain constant, and no result is lost or duplicated after release.
- Assert rst_n low with 3 operations in flight: all outputs go to 0 immediately, and no stale result appears after reset release.
- WIDTH=32, TAG_W=8 instance: 32'hFFFFFFFF × 32'hFFFFFFFF unsigned = 64'hFFFFFFFE00000001 after LAT=7 cycles, and signed -1×-1 = 1.
